// File: rtl/mu_div_pkg.sv
// Shared definitions for the Barrett mu divider: default widths, FSM state
// type and the counter-width helper.
package mu_div_pkg;

  localparam int MOD_W_DEF = 108;
  localparam int SHIFT_DEF = 216;
  // Width that holds floor(2^SHIFT / m) for any m >= 2^(MOD_W-1).
  localparam int MU_W_DEF  = SHIFT_DEF - MOD_W_DEF + 2;
  localparam int CNT_W_DEF = $clog2(SHIFT_DEF + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } mu_div_state_t;

  // Counter width for a given dividend exponent (counts up to SHIFT).
  function automatic int cnt_width(input int shift);
    return $clog2(shift + 2);
  endfunction

endpackage

// File: rtl/barrett_mu_divider_if.sv
// Request/result bundle between a mu consumer and the divider.
//
// Handshake: the master raises start (with m valid) for one or more cycles;
// the divider accepts it only while idle, then holds busy high until the
// computation ends. done is a single-cycle pulse; mu/ovf/err are valid from
// that cycle on and stay unchanged until the next accepted start. A start
// seen while busy or during the done cycle is dropped without effect.
interface barrett_mu_divider_if
  import mu_div_pkg::*;
#(
  parameter int MOD_W = MOD_W_DEF,
  parameter int SHIFT = SHIFT_DEF
);
  localparam int MU_W = SHIFT - MOD_W + 2;

  logic             start;
  logic [MOD_W-1:0] m;
  logic             busy;
  logic             done;
  logic [MU_W-1:0]  mu;
  logic             ovf;
  logic             err;

  modport master (output start, m, input busy, done, mu, ovf, err);
  modport slave  (input start, m, output busy, done, mu, ovf, err);
endinterface

// File: rtl/mu_div_step.sv
// One restoring division step: shift the next dividend bit into the
// remainder and subtract the modulus when it fits. Purely combinational.
module mu_div_step #(
  parameter int MOD_W = 108
) (
  input  logic [MOD_W:0]   r,
  input  logic             dbit,
  input  logic [MOD_W-1:0] m,
  output logic [MOD_W:0]   r_next,
  output logic             qbit
);

  logic [MOD_W:0]   r_shift;
  logic [MOD_W+1:0] diff;

  // Shift, trial-subtract, and keep the difference only when no borrow.
  always_comb begin
    r_shift = {r[MOD_W-1:0], dbit};
    diff    = {1'b0, r_shift} - {2'b00, m};
    // r[MOD_W] set would mean the shifted value exceeds the window and so
    // certainly exceeds m; the borrow bit covers the ordinary case.
    qbit    = r[MOD_W] | ~diff[MOD_W+1];
    r_next  = qbit ? diff[MOD_W:0] : r_shift;
  end

endmodule

// File: rtl/barrett_mu_divider.sv
// Sequential restoring divider producing the Barrett constant
// mu = floor(2^SHIFT / m). Runs once per modulus change, so it uses a single
// subtractor per step and iterates over the SHIFT+1 dividend bits.
// Build option: define MU_DIV_RADIX4_EN to chain two steps per cycle
// (dividend padded with a leading zero to an even length).
module barrett_mu_divider
  import mu_div_pkg::*;
#(
  parameter int MOD_W = MOD_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  barrett_mu_divider_if.slave  bus,
  output mu_div_state_t        state_dbg
);

  localparam int MU_W  = SHIFT - MOD_W + 2;
  localparam int CNT_W = cnt_width(SHIFT);
`ifdef MU_DIV_RADIX4_EN
  localparam int PAD    = (SHIFT + 1) % 2;
  localparam int NSTEPS = (SHIFT + 1 + PAD) / 2;
  // The single 1 of the dividend lands in the upper step of the first pair
  // when no pad is needed, otherwise in the lower step.
  localparam logic ONE_IN_HI = (PAD == 0);
`else
  localparam int NSTEPS = SHIFT + 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEPS - 1);

  mu_div_state_t    state, state_next;
  logic [MOD_W-1:0] m_q;
  logic [MOD_W:0]   r_q;
  logic [MU_W-1:0]  mu_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             err_q;

  logic [MOD_W:0]   r_step;
  logic [MU_W-1:0]  q_step;
  logic             shout;
  logic             first;

  assign first = (cnt_q == '0);

`ifdef MU_DIV_RADIX4_EN
  logic [MOD_W:0] r_mid;
  logic           qb_hi, qb_lo;

  mu_div_step #(.MOD_W(MOD_W)) u_step_hi (
    .r      (r_q),
    .dbit   (first & ONE_IN_HI),
    .m      (m_q),
    .r_next (r_mid),
    .qbit   (qb_hi)
  );

  mu_div_step #(.MOD_W(MOD_W)) u_step_lo (
    .r      (r_mid),
    .dbit   (first & ~ONE_IN_HI),
    .m      (m_q),
    .r_next (r_step),
    .qbit   (qb_lo)
  );

  // Two quotient bits enter per cycle; both bits pushed out feed overflow.
  always_comb begin
    q_step = {mu_q[MU_W-3:0], qb_hi, qb_lo};
    shout  = mu_q[MU_W-1] | mu_q[MU_W-2];
  end
`else
  logic qb;

  mu_div_step #(.MOD_W(MOD_W)) u_step (
    .r      (r_q),
    .dbit   (first),
    .m      (m_q),
    .r_next (r_step),
    .qbit   (qb)
  );

  // One quotient bit enters per cycle; the bit pushed out feeds overflow.
  always_comb begin
    q_step = {mu_q[MU_W-2:0], qb};
    shout  = mu_q[MU_W-1];
  end
`endif

  // Next-state logic: start only counts in IDLE; m == 0 skips the division.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = (bus.m == '0) ? FIN : DIV;
      DIV:     if (cnt_q == LAST_CNT) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath: capture on accept, iterate in DIV, saturate on the last step
  // so mu is already final in the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      r_q   <= '0;
      mu_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m_q   <= bus.m;
            r_q   <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            err_q <= (bus.m == '0);
            mu_q  <= (bus.m == '0) ? '1 : '0;
          end
        end
        DIV: begin
          r_q   <= r_step;
          cnt_q <= cnt_q + 1'b1;
          ovf_q <= ovf_q | shout;
          if ((cnt_q == LAST_CNT) && (ovf_q | shout)) mu_q <= '1;
          else                                        mu_q <= q_step;
        end
        default: ;
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    bus.busy  = (state != IDLE) && (state != FIN);
    bus.done  = (state == FIN);
    bus.mu    = mu_q;
    bus.ovf   = ovf_q;
    bus.err   = err_q;
    state_dbg = state;
  end

endmodule

// File: tb/tb_barrett_mu_divider.sv
// Directed bench for barrett_mu_divider: a default-width instance and a
// small MOD_W=8/SHIFT=16 instance. Latencies follow MU_DIV_RADIX4_EN.
module tb_barrett_mu_divider;
  import mu_div_pkg::*;

  localparam int BW  = 108;
  localparam int BS  = 216;
  localparam int BMU = 110;
  localparam int SW  = 8;
  localparam int SS  = 16;
  localparam int SMU = 10;
`ifdef MU_DIV_RADIX4_EN
  localparam int B_LAT = 109;
  localparam int S_LAT = 9;
`else
  localparam int B_LAT = 217;
  localparam int S_LAT = 17;
`endif
  localparam int LIMIT = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  barrett_mu_divider_if #(.MOD_W(BW), .SHIFT(BS)) b_if ();
  barrett_mu_divider_if #(.MOD_W(SW), .SHIFT(SS)) s_if ();
  mu_div_state_t b_state, s_state;

  barrett_mu_divider #(.MOD_W(BW), .SHIFT(BS)) u_big (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (b_if),
    .state_dbg (b_state)
  );

  barrett_mu_divider #(.MOD_W(SW), .SHIFT(SS)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (s_if),
    .state_dbg (s_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; start is seen by the next posedge.
  task automatic big_start(input logic [BW-1:0] mv);
    b_if.start = 1'b1;
    b_if.m     = mv;
    @(negedge clk);
    b_if.start = 1'b0;
  endtask

  task automatic small_start(input logic [SW-1:0] mv);
    s_if.start = 1'b1;
    s_if.m     = mv;
    @(negedge clk);
    s_if.start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic big_wait(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (b_if.done !== 1'b1 && lat < LIMIT) begin
      if (b_if.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic small_wait(output int lat);
    lat = 0;
    while (s_if.done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    logic busy_ok;
    int done_seen;
    logic [BMU-1:0] mu_2p109, mu_2p108p1, mu_ones;
    logic [BW-1:0]  m_2p107, m_2p108m1;

    mu_2p109   = BMU'(1) << 109;
    mu_2p108p1 = (BMU'(1) << 108) + BMU'(1);
    mu_ones    = '1;
    m_2p107    = BW'(1) << 107;
    m_2p108m1  = '1;

    rst_n = 1'b0;
    b_if.start = 1'b0; b_if.m = '0;
    s_if.start = 1'b0; s_if.m = '0;
    @(negedge clk);
    check("reset busy", b_if.busy, 0);
    check("reset done", b_if.done, 0);
    check("reset mu", b_if.mu, 0);
    check("reset ovf", b_if.ovf, 0);
    check("reset err", b_if.err, 0);
    check("reset state", b_state, IDLE);
    check("reset small mu", s_if.mu, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // m = 2^107 -> mu = 2^109
    big_start(m_2p107);
    big_wait(lat, busy_ok);
    check("2^107 latency", lat, B_LAT);
    check("2^107 busy held", busy_ok, 1);
    check("2^107 busy at done", b_if.busy, 0);
    check("2^107 mu", b_if.mu, mu_2p109);
    check("2^107 ovf", b_if.ovf, 0);
    check("2^107 err", b_if.err, 0);
    @(negedge clk);
    check("done single cycle", b_if.done, 0);
    check("mu held", b_if.mu, mu_2p109);

    // m = 2^108-1 -> mu = 2^108+1
    big_start(m_2p108m1);
    big_wait(lat, busy_ok);
    check("max m latency", lat, B_LAT);
    check("max m mu", b_if.mu, mu_2p108p1);
    check("max m ovf", b_if.ovf, 0);
    @(negedge clk);

    // m = 0 -> error, done next cycle
    big_start('0);
    big_wait(lat, busy_ok);
    check("m0 latency", lat, 0);
    check("m0 err", b_if.err, 1);
    check("m0 mu", b_if.mu, mu_ones);
    check("m0 ovf", b_if.ovf, 0);
    @(negedge clk);

    // m = 3 -> overflow, saturated mu
    big_start(BW'(3));
    big_wait(lat, busy_ok);
    check("m3 latency", lat, B_LAT);
    check("m3 ovf", b_if.ovf, 1);
    check("m3 mu", b_if.mu, mu_ones);
    check("m3 err", b_if.err, 0);
    @(negedge clk);

    // start re-pulsed mid-run is ignored
    big_start(m_2p107);
    repeat (50) @(negedge clk);
    b_if.start = 1'b1;
    b_if.m     = BW'(3);
    @(negedge clk);
    b_if.start = 1'b0;
    big_wait(lat, busy_ok);
    check("restart latency", lat + 51, B_LAT);
    check("restart mu", b_if.mu, mu_2p109);
    check("restart ovf", b_if.ovf, 0);

    // start during done cycle ignored, next cycle accepted
    b_if.start = 1'b1;
    b_if.m     = BW'(3);
    @(negedge clk);
    check("start in done ignored busy", b_if.busy, 0);
    check("start in done no done", b_if.done, 0);
    big_start(m_2p108m1);
    big_wait(lat, busy_ok);
    check("start after done latency", lat, B_LAT);
    check("start after done mu", b_if.mu, mu_2p108p1);
    @(negedge clk);

    // asynchronous reset mid-run
    big_start(m_2p107);
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", b_if.busy, 0);
    check("async rst done", b_if.done, 0);
    check("async rst mu", b_if.mu, 0);
    check("async rst ovf", b_if.ovf, 0);
    check("async rst err", b_if.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (b_if.done === 1'b1) done_seen++;
    end
    check("no done after abort", done_seen, 0);
    big_start(m_2p108m1);
    big_wait(lat, busy_ok);
    check("post-reset latency", lat, B_LAT);
    check("post-reset mu", b_if.mu, mu_2p108p1);
    @(negedge clk);

    // small instance: m = 200 -> 327
    small_start(SW'(200));
    small_wait(lat);
    check("small m200 latency", lat, S_LAT);
    check("small m200 mu", s_if.mu, 327);
    check("small m200 ovf", s_if.ovf, 0);
    @(negedge clk);

    // sweep m = 128..255 against floor(65536/m)
    for (int k = 128; k < 256; k++) begin
      small_start(SW'(k));
      small_wait(lat);
      check($sformatf("sweep m=%0d", k), s_if.mu, 65536 / k);
      @(negedge clk);
    end

    // small m = 1 -> 65536 does not fit 10 bits
    small_start(SW'(1));
    small_wait(lat);
    check("small m1 ovf", s_if.ovf, 1);
    check("small m1 mu", s_if.mu, {SMU{1'b1}});
    check("small m1 state", s_state, FIN);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
